// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction memory loader
package mips_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        CHECK
    } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs accepted bytes big-endian into one instruction word
module imem_word_packer
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            byte_data,
    output logic [WORD_WIDTH-1:0] word,
    output logic [1:0]            byte_cnt
);

    logic word_full;

    // The word is kept across clear so it stays valid while the top writes it out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word      <= '0;
            byte_cnt  <= 2'd0;
            word_full <= 1'b0;
        end else if (clear) begin
            byte_cnt  <= 2'd0;
            word_full <= 1'b0;
        end else if (accept && !word_full) begin
            word      <= {word[WORD_WIDTH-9:0], byte_data};
            byte_cnt  <= byte_cnt + 2'd1;
            word_full <= (byte_cnt == 2'(BYTES_PER_WORD - 1));
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader; optional IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error
);

    import mips_pkg::*;

    loader_state_t         state;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            pk_cnt;
    logic                  accept;
    logic                  len_bad;
    logic                  last_word;

    assign accept    = s_valid && s_ready;
    // Anything above 2**ADDR_WIDTH has the top bit set plus at least one lower bit.
    assign len_bad   = load_len[ADDR_WIDTH] && (|load_len[ADDR_WIDTH-1:0]);
    assign last_word = ({1'b0, word_idx} == (len_q - (ADDR_WIDTH+1)'(1)));

    imem_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state != RECV),
        .accept    (accept && (state == RECV)),
        .byte_data (s_data),
        .word      (imem_wdata),
        .byte_cnt  (pk_cnt)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'd0;
        end else if (state == IDLE) begin
            csum <= 8'd0;
        end else if (state == RECV && accept) begin
            csum <= csum + s_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            word_idx   <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            cpu_hold   <= 1'b1;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (len_bad) begin
                            load_error <= 1'b1;
                        end else begin
                            load_error <= 1'b0;
                            len_q      <= load_len;
                            word_idx   <= '0;
                            load_busy  <= 1'b1;
                            if (load_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                cpu_hold <= 1'b1;
                                s_ready  <= 1'b1;
                                state    <= CHECK;
`else
                                cpu_hold  <= 1'b0;
                                load_done <= 1'b1;
                                state     <= DONE;
`endif
                            end else begin
                                cpu_hold <= 1'b1;
                                s_ready  <= 1'b1;
                                state    <= RECV;
                            end
                        end
                    end
                end
                RECV: begin
                    if (accept && pk_cnt == 2'(BYTES_PER_WORD - 1)) begin
                        s_ready   <= 1'b0;
                        imem_we   <= 1'b1;
                        imem_addr <= word_idx;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        s_ready <= 1'b1;
                        state   <= CHECK;
`else
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                        state     <= DONE;
`endif
                    end else begin
                        word_idx <= word_idx + ADDR_WIDTH'(1);
                        s_ready  <= 1'b1;
                        state    <= RECV;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        s_ready <= 1'b0;
                        if (s_data == csum) begin
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            load_error <= 1'b1;
                            load_busy  <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
`endif
                DONE: begin
                    load_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    s_ready   <= 1'b0;
                    load_busy <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that writes the instruction memory of the single-cycle MIPS core through its write port, instead of preloading it by hierarchical backdoor. It accepts a byte stream over a valid/ready handshake, packs four bytes into one big-endian 32-bit word, and writes consecutive word addresses starting at 0. It holds the core in reset until a load completes, then releases it so fetch starts at PC 0.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction memory; DEPTH = 2**ADDR_WIDTH words
WORD_WIDTH, 32, instruction width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
load_start  input  1  single-cycle pulse; begins a load (ignored unless IDLE)
load_len  input  ADDR_WIDTH+1  number of words to load; sampled on an accepted load_start
s_valid  input  1  byte stream valid
s_data  input  8  byte stream data
s_ready  output  1  byte accepted when s_valid && s_ready
imem_we  output  1  instruction memory write enable, one cycle per word
imem_addr  output  ADDR_WIDTH  word address (byte address = imem_addr<<2)
imem_wdata  output  32  packed instruction word
cpu_hold  output  1  drives the core's reset; 1 = core held
load_busy  output  1  1 in any state other than IDLE
load_done  output  1  one-cycle pulse when a load finishes successfully
load_error  output  1  sticky; cleared by the next accepted load_start or by reset

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high, on port reset, with clock port clk.
- Reset values: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_busy=0, load_done=0, load_error=0, state=IDLE, byte_cnt=0, word_idx=0.
- States: IDLE, RECV, WRITE, DONE (and CHECK when the optional feature is enabled).
- IDLE: s_ready=0.
  - On load_start with load_len > DEPTH: set load_error=1, leave cpu_hold unchanged, stay IDLE.
  - On load_start with load_len == 0: go to DONE with no writes.
  - Otherwise: latch load_len, clear load_error, set cpu_hold=1, word_idx=0, byte_cnt=0, go to RECV.
- RECV: s_ready=1.
  - Each accepted byte shifts into the word buffer: first byte -> bits 31:24, fourth byte -> bits 7:0.
  - byte_cnt increments per accepted byte.
  - When the 4th byte is accepted, go to WRITE next cycle.
  - No accept when s_valid=0; stalls are unbounded.
- WRITE: s_ready=0.
  - imem_we=1 for exactly one cycle, with imem_addr=word_idx and imem_wdata=packed word.
  - If word_idx == len-1, go to DONE; else word_idx++, byte_cnt=0, go to RECV.
  - Throughput: 5 cycles per word minimum (4 accepts + 1 write).
- DONE: load_done=1 for one cycle, cpu_hold deasserts on the same edge; go to IDLE.
  - The core comes out of reset the cycle after load_done.
- load_start while load_busy=1 is ignored, with no effect on state or outputs.
- Bytes presented in IDLE/WRITE/DONE are not accepted (s_ready=0). The source holds them.
- An assertion of reset mid-load aborts immediately to reset values. cpu_hold=1. Partially written memory is not cleared.
- Word address never wraps: the len <= DEPTH check guarantees word_idx <= DEPTH-1.
- Outputs are registered; no combinational path from s_valid to s_ready.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN.
- Defined: after the last WRITE, go to CHECK instead of DONE, with s_ready=1. Accept one extra byte and compare it with the 8-bit modulo-256 sum of all data bytes.
  - Match: go to DONE.
  - Mismatch: set load_error=1, keep cpu_hold=1, no load_done, go to IDLE.
  - len==0 expects checksum byte 0x00.
- Undefined: there is no CHECK state, no extra byte and no running sum register.

Decomposition:
- Package mips_pkg gets the loader state enum (IDLE/RECV/WRITE/DONE/CHECK), BYTES_PER_WORD=4 and WORD_WIDTH=32.
- One natural sub-module, imem_word_packer: a byte shift register, 2-bit byte counter and word_full flag.
- The top holds the FSM, address counter, checksum and hold/done logic.

Test Plan:
- Load of 2 words, continuous valid: load_len=2, bytes 00 64 10 20, 00 65 18 22 -> imem_we pulses at addr 0 with 0x00641020, then at addr 1 with 0x00651822; load_done once; cpu_hold falls with it.
- Backpressure/gaps: same 2 words with s_valid low for 3 cycles between every byte -> identical writes, no extra or duplicated bytes, s_ready=0 during WRITE.
- Boundary lengths:
  - load_len=0 -> load_done in 2 cycles, no imem_we.
  - load_len=257 (ADDR_WIDTH=8) -> load_error=1, state IDLE, no writes.
  - load_len=256 -> last write at addr 255.
- Ignored start: pulse load_start during RECV of word 0 with load_len=5 -> transfer continues with the original len=2.
- Reset mid-load: assert reset after 2 bytes of word 1 -> all outputs at reset values, cpu_hold=1. A subsequent full load of 1 word 0x8C040004 writes addr 0 correctly.
- Checksum (macro defined): 1 word 8C 04 00 04 plus checksum 0x94 -> load_done. Same word plus 0x95 -> load_error=1, cpu_hold stays 1.
